// File: rtl/sseg_scan_controller_pkg.sv
// Shared constants for the seven-segment scan controller.
//   SEG_A..SEG_DP : bit positions inside the 8-bit cathode word {dp,g,f,e,d,c,b,a}
//   CATHODE_OFF   : all segments dark (cathodes are active-high)
//   ANODE_OFF     : all digits deselected (anodes are active-low); slice to NUM_DIGITS
//   scan_state_t  : scan FSM state encoding
package sseg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] CATHODE_OFF = 8'h00;
  localparam logic [7:0] ANODE_OFF   = 8'hFF;

  typedef enum logic {
    ST_DARK = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/sseg_scan_controller_decoder.sv
// SSEG_Decoder: hex nibble to active-high segment pattern.
// Ports:
//   num     in  4  hex digit 0..F
//   cathode out 8  {dp,g,f,e,d,c,b,a}; dp is always 0 here, the caller merges it
module SSEG_Decoder
  import sseg_pkg::*;
(
  input  logic [3:0] num,
  output logic [7:0] cathode
);

  always_comb begin
    cathode = CATHODE_OFF;
    case (num)
      4'h0:    cathode[SEG_G:SEG_A] = 7'h3F;
      4'h1:    cathode[SEG_G:SEG_A] = 7'h06;
      4'h2:    cathode[SEG_G:SEG_A] = 7'h5B;
      4'h3:    cathode[SEG_G:SEG_A] = 7'h4F;
      4'h4:    cathode[SEG_G:SEG_A] = 7'h66;
      4'h5:    cathode[SEG_G:SEG_A] = 7'h6D;
      4'h6:    cathode[SEG_G:SEG_A] = 7'h7D;
      4'h7:    cathode[SEG_G:SEG_A] = 7'h07;
      4'h8:    cathode[SEG_G:SEG_A] = 7'h7F;
      4'h9:    cathode[SEG_G:SEG_A] = 7'h6F;
      4'hA:    cathode[SEG_G:SEG_A] = 7'h77;
      4'hB:    cathode[SEG_G:SEG_A] = 7'h7C;
      4'hC:    cathode[SEG_G:SEG_A] = 7'h39;
      4'hD:    cathode[SEG_G:SEG_A] = 7'h5E;
      4'hE:    cathode[SEG_G:SEG_A] = 7'h79;
      default: cathode[SEG_G:SEG_A] = 7'h71;
    endcase
  end

endmodule

// File: rtl/sseg_scan_controller.sv
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
// A pending register captures value/dp_mask on load; the display shadow only
// takes the pending word at a frame end, so a frame is never drawn with mixed data.
// Each digit slot starts with BLANK_CYCLES of all-anodes-off to stop ghosting.
// Optional feature: define SSEG_LEADING_ZERO_BLANK_EN to blank leading-zero digits
// (digit 0 and digits with dp set are always shown).
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high
//   enable     in   1 = scan, 0 = dark with scan position held at digit 0
//   value      in   packed nibbles, nibble i -> digit i (digit 0 rightmost)
//   dp_mask    in   decimal point per digit
//   load       in   strobe capturing value/dp_mask into the pending register
//   anode      out  active-low digit select, at most one bit low
//   cathode    out  {dp,g,f,e,d,c,b,a}, active-high
//   frame_done out  high during the last cycle of the last digit slot
//
// state   | meaning
// ST_DARK | display off, slot counter and digit index held at 0
// ST_SCAN | counting slots and cycling through the digits
module sseg_scan_controller
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [7:0]              cathode,
  output logic                    frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0]         CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]         CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODES_OFF = ANODE_OFF[NUM_DIGITS-1:0];

  scan_state_t             state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [NUM_DIGITS-1:0]   anode_nxt;
  logic [7:0]              cathode_nxt;

  logic [4*NUM_DIGITS-1:0] pend_val, shad_val;
  logic [NUM_DIGITS-1:0]   pend_dp, shad_dp;
  logic                    pend_valid;

  logic [NUM_DIGITS-1:0]   digit_lit;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic [3:0]              sel_nib;
  logic                    sel_dp;
  logic                    sel_lit;
  logic [7:0]              dec_cathode;

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  logic any_above;

  // Scan from the top digit down; once a non-zero nibble is seen, everything
  // from there to digit 0 is significant.
  always_comb begin
    any_above = 1'b0;
    digit_lit = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      any_above    = any_above | (|shad_val[4*i +: 4]);
      digit_lit[i] = (i == 0) || shad_dp[i] || any_above;
    end
  end
`else
  assign digit_lit = '1;
`endif

  always_comb begin
    sel_nib   = 4'h0;
    sel_dp    = 1'b0;
    sel_lit   = 1'b0;
    digit_sel = ANODES_OFF;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        sel_nib      = shad_val[4*i +: 4];
        sel_dp       = shad_dp[i];
        sel_lit      = digit_lit[i];
        digit_sel[i] = 1'b0;
      end
    end
  end

  SSEG_Decoder u_decoder (
    .num     (sel_nib),
    .cathode (dec_cathode)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_DARK;
      cnt     <= '0;
      idx     <= '0;
      anode   <= ANODES_OFF;
      cathode <= CATHODE_OFF;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      anode   <= anode_nxt;
      cathode <= cathode_nxt;
    end
  end

  // Outputs are registered from the current position, so dropping enable
  // darkens the display on the very next edge.
  always_comb begin
    state_nxt   = enable ? ST_SCAN : ST_DARK;
    cnt_nxt     = '0;
    idx_nxt     = '0;
    anode_nxt   = ANODES_OFF;
    cathode_nxt = CATHODE_OFF;
    frame_done  = 1'b0;
    case (state)
      ST_SCAN: begin
        frame_done = (cnt == CNT_LAST) && (idx == IDX_LAST);
        if (enable) begin
          if (cnt == CNT_LAST) begin
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
            idx_nxt = idx;
          end
          if ((cnt >= CNT_BLANK) && sel_lit) begin
            anode_nxt           = digit_sel;
            cathode_nxt         = dec_cathode;
            cathode_nxt[SEG_DP] = sel_dp;
          end
        end
      end
      default: ;
    endcase
  end

  // A load coinciding with the frame end bypasses pending and lands in shadow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      shad_val   <= '0;
      shad_dp    <= '0;
    end else if (frame_done) begin
      pend_valid <= 1'b0;
      if (load) begin
        shad_val <= value;
        shad_dp  <= dp_mask;
      end else if (pend_valid) begin
        shad_val <= pend_val;
        shad_dp  <= pend_dp;
      end
    end else if (load) begin
      pend_val   <= value;
      pend_dp    <= dp_mask;
      pend_valid <= 1'b1;
    end
  end

endmodule
